// File: rtl/alu_exec_seq.sv
// Execute sequencer feeding the 4-bit ALU: operand fetch from a one-port
// register file, registered ALU drive, flag update and write-back.
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 3
`endif

module alu_exec_seq #(
    parameter int WIDTH    = 4,
    parameter int NREGS    = 4,
    parameter int RADDR_W  = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [`ALU_OP_LEN-1:0] issue_op,
    input  logic [RADDR_W-1:0]     issue_rd,
    input  logic [RADDR_W-1:0]     issue_rs1,
    input  logic [RADDR_W-1:0]     issue_rs2,
    input  logic                   issue_use_imm,
    input  logic [WIDTH-1:0]       issue_imm,
    output logic                   rf_re,
    output logic [RADDR_W-1:0]     rf_raddr,
    input  logic [WIDTH-1:0]       rf_rdata,
    output logic                   rf_we,
    output logic [RADDR_W-1:0]     rf_waddr,
    output logic [WIDTH-1:0]       rf_wdata,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [`ALU_OP_LEN-1:0] alu_op,
    input  logic [WIDTH-1:0]       alu_y,
    output logic                   flag_z,
    output logic                   flag_n,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_LD_B, S_EX, S_WB
    } state_e;

    state_e                  state_q, state_d;
    logic [`ALU_OP_LEN-1:0]  op_q, op_d;
    logic [RADDR_W-1:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic                    use_imm_q, use_imm_d;
    logic [WIDTH-1:0]        imm_q, imm_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]        res_q, res_d;
    logic                    fz_q, fz_d, fn_q, fn_d;
    logic [RADDR_W-1:0]      raddr_q, raddr_d, waddr_q, waddr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic                    accept, wr_en;

    assign accept = issue_valid && (state_q == S_IDLE);

    // R0 stays zero when hardwired; out-of-range addresses never write
    assign wr_en = !((ZERO_REG != 0) && (rd_q == '0))
                && ({{(32-RADDR_W){1'b0}}, rd_q} < NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            fz_q      <= 1'b0;
            fn_q      <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            fz_q      <= fz_d;
            fn_q      <= fn_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (issue_valid) state_d = S_RD_A;
            S_RD_A:  state_d = S_RD_B;
            S_RD_B:  state_d = use_imm_q ? S_EX : S_LD_B;
            S_LD_B:  state_d = S_EX;
            S_EX:    state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_ready = 1'b0;
        rf_re       = 1'b0;
        rf_we       = 1'b0;
        done        = 1'b0;
        rf_raddr    = raddr_q;
        rf_waddr    = waddr_q;
        rf_wdata    = wdata_q;
        unique case (state_q)
            S_IDLE: issue_ready = 1'b1;
            S_RD_A: begin
                rf_re    = 1'b1;
                rf_raddr = rs1_q;
            end
            S_RD_B: if (!use_imm_q) begin
                rf_re    = 1'b1;
                rf_raddr = rs2_q;
            end
            S_WB: begin
                done  = 1'b1;
                rf_we = wr_en;
                if (wr_en) begin
                    rf_waddr = rd_q;
                    rf_wdata = res_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        fz_d      = fz_q;
        fn_d      = fn_q;
        raddr_d   = rf_raddr;
        waddr_d   = rf_waddr;
        wdata_d   = rf_wdata;
        if (accept) begin
            op_d      = issue_op;
            rd_d      = issue_rd;
            rs1_d     = issue_rs1;
            rs2_d     = issue_rs2;
            use_imm_d = issue_use_imm;
            imm_d     = issue_imm;
        end
        if (state_q == S_RD_B) begin
            a_d = rf_rdata;
            if (use_imm_q) b_d = imm_q;
        end
        if (state_q == S_LD_B) b_d = rf_rdata;
        if (state_q == S_EX) begin
            res_d = alu_y;
            fz_d  = (alu_y == '0);
            fn_d  = alu_y[WIDTH-1];
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign flag_z = fz_q;
    assign flag_n = fn_q;

endmodule
